// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Address-fault helper is shared by the fetch path and the load port.
package imem_responder_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] IMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] addr;
    logic            err;
  } imem_rsp_t;

  // The subtraction is only trusted once addr >= base, so it cannot wrap.
  function automatic logic addr_fault(input logic [XLEN-1:0] addr,
                                      input logic [XLEN-1:0] base,
                                      input logic [XLEN-1:0] span);
    logic [XLEN-1:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || (off >= span);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channels, flush and load port of the responder.
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic            req_valid_i;
  logic            req_ready_o;
  logic [XLEN-1:0] req_addr_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [31:0]     rsp_instr_o;
  logic [XLEN-1:0] rsp_addr_o;
  logic            rsp_err_o;
  logic            flush_i;
  logic            ld_we_i;
  logic [XLEN-1:0] ld_addr_i;
  logic [31:0]     ld_data_i;

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, flush_i,
           ld_we_i, ld_addr_i, ld_data_i,
    input  req_ready_o, rsp_valid_o, rsp_instr_o, rsp_addr_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, flush_i,
           ld_we_i, ld_addr_i, ld_data_i,
    output req_ready_o, rsp_valid_o, rsp_instr_o, rsp_addr_o, rsp_err_o
  );

endinterface

// File: rtl/imem_responder_rsp_fifo.sv
// Two-entry response buffer with push, pop and flush.
// A push in the flush cycle lands in slot 0 after the clear.
module imem_rsp_fifo
  import imem_responder_pkg::*;
(
  input  logic      clk_i,
  input  logic      rstn_i,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  imem_rsp_t din,
  output imem_rsp_t head,
  output logic [1:0] count
);

  imem_rsp_t slot [2];
  logic      wr_ptr;
  logic      rd_ptr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      if (push) begin
        slot[0] <= din;
        wr_ptr  <= 1'b1;
        count   <= 2'd1;
      end else begin
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end
    end else begin
      if (push) begin
        slot[wr_ptr] <= din;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = slot[rd_ptr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: word array, fault check, load port and
// valid/ready handshake in front of a two-entry response buffer.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int              MEM_SIZE   = 2048,
  parameter logic [XLEN-1:0] BASE_ADDR  = IMEM_BASE,
  parameter int              FIFO_DEPTH = 2
) (
  input logic              clk_i,
  input logic              rstn_i,
  imem_responder_if.slave  bus
);

  localparam int              IDX_W = $clog2(MEM_SIZE);
  localparam logic [XLEN-1:0] SPAN  = XLEN'(4 * MEM_SIZE);

  logic [31:0]      mem [MEM_SIZE];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             req_fault;
  logic             ld_fault;
  logic             ready;
  logic             push;
  logic             pop;
  logic             valid;
  logic [1:0]       count;
  imem_rsp_t        entry;
  imem_rsp_t        head;

  assign req_fault = addr_fault(bus.req_addr_i, BASE_ADDR, SPAN);
  assign ld_fault  = addr_fault(bus.ld_addr_i, BASE_ADDR, SPAN);
  assign rd_idx    = IDX_W'((bus.req_addr_i - BASE_ADDR) >> 2);
  assign wr_idx    = IDX_W'((bus.ld_addr_i - BASE_ADDR) >> 2);

  // Combinational read sees the pre-edge contents, so a same-word load is read-first.
  always_comb begin
    entry       = '0;
    entry.addr  = bus.req_addr_i;
    entry.err   = req_fault;
    entry.instr = req_fault ? NOP_INSTR : mem[rd_idx];
  end

  always_ff @(posedge clk_i) begin
    if (bus.ld_we_i && !ld_fault) mem[wr_idx] <= bus.ld_data_i;
  end

  // Ready depends only on occupancy so there is no path from rsp_ready_i.
  assign ready = rstn_i && (count != 2'(FIFO_DEPTH));
  assign push  = bus.req_valid_i && ready;
  assign valid = (count != 2'd0);
  assign pop   = valid && bus.rsp_ready_i;

  imem_rsp_fifo u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (push),
    .pop    (pop),
    .flush  (bus.flush_i),
    .din    (entry),
    .head   (head),
    .count  (count)
  );

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = valid;
  assign bus.rsp_instr_o = head.instr;
  assign bus.rsp_addr_o  = head.addr;
  assign bus.rsp_err_o   = head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: handshake, faults, flush, read-first
// load collision and asynchronous reset, checked with immediate assertions.
module tb_imem_responder;
  import imem_responder_pkg::*;

  logic clk;
  logic rstn;
  int   passed;
  int   total;

  imem_responder_if bus ();

  imem_responder dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.ld_we_i   = 1'b1;
    bus.ld_addr_i = a;
    bus.ld_data_i = d;
    step();
    bus.ld_we_i   = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rstn   = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    bus.ld_we_i     = 1'b0;
    bus.ld_addr_i   = '0;
    bus.ld_data_i   = '0;
    #1;
    check("rst_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_instr", bus.rsp_instr_o, 32'h0);
    check("rst_addr",  bus.rsp_addr_o, 32'h0);
    check("rst_err",   32'(bus.rsp_err_o), 32'd0);
    step();
    step();
    rstn = 1'b1;
    #1;
    check("rel_ready", 32'(bus.req_ready_o), 32'd1);
    step();

    // 1: preload and back-to-back fetch
    load(32'h8000_0000, 32'h0050_0093);
    load(32'h8000_0004, 32'h00A0_0113);
    load(32'h8000_0008, 32'h1111_1111);
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_0000;
    step();
    bus.req_addr_i  = 32'h8000_0004;
    check("t1_valid0", 32'(bus.rsp_valid_o), 32'd1);
    check("t1_instr0", bus.rsp_instr_o, 32'h0050_0093);
    check("t1_addr0",  bus.rsp_addr_o, 32'h8000_0000);
    check("t1_err0",   32'(bus.rsp_err_o), 32'd0);
    step();
    bus.req_valid_i = 1'b0;
    check("t1_valid1", 32'(bus.rsp_valid_o), 32'd1);
    check("t1_instr1", bus.rsp_instr_o, 32'h00A0_0113);
    check("t1_addr1",  bus.rsp_addr_o, 32'h8000_0004);
    step();
    check("t1_empty", 32'(bus.rsp_valid_o), 32'd0);

    // 2: back-pressure, third request waits for the first pop
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_0000;
    step();
    bus.req_addr_i  = 32'h8000_0004;
    check("t2_ready_one", 32'(bus.req_ready_o), 32'd1);
    step();
    bus.req_addr_i  = 32'h8000_0008;
    check("t2_ready_full", 32'(bus.req_ready_o), 32'd0);
    step();
    check("t2_hold_full", 32'(bus.req_ready_o), 32'd0);
    check("t2_head0", bus.rsp_addr_o, 32'h8000_0000);
    bus.rsp_ready_i = 1'b1;
    check("t2_no_comb", 32'(bus.req_ready_o), 32'd0);
    check("t2_instr0", bus.rsp_instr_o, 32'h0050_0093);
    step();
    check("t2_ready_after_pop", 32'(bus.req_ready_o), 32'd1);
    check("t2_head1", bus.rsp_addr_o, 32'h8000_0004);
    check("t2_instr1", bus.rsp_instr_o, 32'h00A0_0113);
    step();
    bus.req_valid_i = 1'b0;
    check("t2_head2", bus.rsp_addr_o, 32'h8000_0008);
    check("t2_instr2", bus.rsp_instr_o, 32'h1111_1111);
    step();
    check("t2_empty", 32'(bus.rsp_valid_o), 32'd0);

    // 3: faults and last in-range word
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_2000;
    step();
    bus.req_addr_i  = 32'h8000_0002;
    check("t3_oor_err",   32'(bus.rsp_err_o), 32'd1);
    check("t3_oor_instr", bus.rsp_instr_o, NOP_INSTR);
    check("t3_oor_addr",  bus.rsp_addr_o, 32'h8000_2000);
    step();
    bus.req_addr_i  = 32'h7FFF_FFFC;
    check("t3_mis_err",   32'(bus.rsp_err_o), 32'd1);
    check("t3_mis_instr", bus.rsp_instr_o, NOP_INSTR);
    step();
    bus.req_addr_i  = 32'h8000_1FFC;
    check("t3_low_err",   32'(bus.rsp_err_o), 32'd1);
    check("t3_low_instr", bus.rsp_instr_o, NOP_INSTR);
    check("t3_low_addr",  bus.rsp_addr_o, 32'h7FFF_FFFC);
    step();
    bus.req_valid_i = 1'b0;
    check("t3_last_ok", 32'(bus.rsp_err_o), 32'd0);
    step();

    // 4: flush of a full buffer, then flush with a concurrent accept
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_0000;
    step();
    bus.req_addr_i  = 32'h8000_0008;
    step();
    bus.req_valid_i = 1'b0;
    check("t4_full_valid", 32'(bus.rsp_valid_o), 32'd1);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("t4_flushed_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("t4_flushed_ready", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_0000;
    step();
    bus.req_addr_i  = 32'h8000_0004;
    bus.flush_i     = 1'b1;
    check("t4_accept_ready", 32'(bus.req_ready_o), 32'd1);
    step();
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    check("t4_kept_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("t4_kept_addr",  bus.rsp_addr_o, 32'h8000_0004);
    check("t4_kept_instr", bus.rsp_instr_o, 32'h00A0_0113);
    bus.rsp_ready_i = 1'b1;
    step();
    check("t4_count_one", 32'(bus.rsp_valid_o), 32'd0);

    // 5: read-first collision, and ignored faulting loads
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_0008;
    load(32'h8000_0008, 32'hDEAD_BEEF);
    check("t5_old", bus.rsp_instr_o, 32'h1111_1111);
    step();
    bus.req_valid_i = 1'b0;
    check("t5_new", bus.rsp_instr_o, 32'hDEAD_BEEF);
    step();
    load(32'h8000_0006, 32'hFFFF_FFFF);
    load(32'h8000_2000, 32'hFFFF_FFFF);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_0004;
    step();
    bus.req_addr_i  = 32'h8000_0000;
    check("t5_mis_ignored", bus.rsp_instr_o, 32'h00A0_0113);
    step();
    bus.req_valid_i = 1'b0;
    check("t5_oor_ignored", bus.rsp_instr_o, 32'h0050_0093);
    step();

    // 6: asynchronous reset with a full buffer
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_0000;
    step();
    bus.req_addr_i  = 32'h8000_0004;
    step();
    bus.req_valid_i = 1'b0;
    check("t6_full", 32'(bus.req_ready_o), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("t6_rst_ready", 32'(bus.req_ready_o), 32'd0);
    check("t6_rst_instr", bus.rsp_instr_o, 32'h0);
    #1;
    rstn = 1'b1;
    #1;
    check("t6_rel_ready", 32'(bus.req_ready_o), 32'd1);
    check("t6_rel_valid", 32'(bus.rsp_valid_o), 32'd0);
    step();
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8000_0008;
    step();
    bus.req_valid_i = 1'b0;
    check("t6_mem_kept", bus.rsp_instr_o, 32'hDEAD_BEEF);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
